hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Sequences all writes to the HI/LO register pair. Sits beside the EX stage.
//  Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO and runs an iterative shift-add multiplier
//  or a restoring divider. Stalls the pipeline while busy. Emits a single-cycle
//  write (we/hi/lo) that drives the HI/LO register write port.
// PARAMETERS
//  DATA_W  32  operand width; HI/LO are each DATA_W bits; iteration count = DATA_W
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       reset, asynchronous, active-low
//  op_valid_i  in   1       op_i/src_*_i valid this cycle
//  op_i        in   3       0 NOP,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 rsvd(=NOP)
//  src_a_i     in   DATA_W  rs operand (multiplicand/dividend/MTHI-MTLO data)
//  src_b_i     in   DATA_W  rt operand (multiplier/divisor)
//  flush_i     in   1       abort in-flight op (exception/branch flush)
//  hi_cur_i    in   DATA_W  current HI value (merged on MTLO)
//  lo_cur_i    in   DATA_W  current LO value (merged on MTHI)
//  busy_o      out  1       stall request; high whenever state != IDLE
//  hilo_we_o   out  1       one-cycle write strobe to HI/LO register
//  hi_o        out  DATA_W  HI write data, valid when hilo_we_o
//  lo_o        out  DATA_W  LO write data, valid when hilo_we_o
// BEHAVIOUR
//  - Clock/reset: one clock; reset is asynchronous and active-low.
//  - Reset (async, any state): state=IDLE, counter=0, busy_o=0, hilo_we_o=0, hi_o=0, lo_o=0.
//  - All outputs registered. Op accepted on an edge where op_valid_i && !busy_o && !flush_i.
//    While busy_o=1, op_valid_i is ignored; upstream holds the instruction.
//  - FSM: IDLE -> MUL|DIV|DONE; MUL -> DONE; DIV -> DONE; DONE -> IDLE.
//  - MTHI/MTLO: IDLE->DONE. Next cycle hilo_we_o=1, with hi_o=src_a_i, lo_o=lo_cur_i (MTHI)
//    or hi_o=hi_cur_i, lo_o=src_a_i (MTLO). Latency 1 cycle. busy_o=1 in DONE.
//  - MULT/MULTU/DIV/DIVU: on accept, latch |a|,|b| (signed ops), store result signs,
//    and load counter=DATA_W-1. Perform one iteration per cycle in MUL/DIV.
//    Leave when counter==0, giving DATA_W cycles. hilo_we_o pulses in DONE,
//    DATA_W+1 cycles after the accept edge. busy_o is high for DATA_W+1 cycles.
//  - Multiply: 2*DATA_W product; HI=upper, LO=lower. Signed: negate product if sign(a)^sign(b).
//  - Divide: LO=quotient, HI=remainder. Signed: quotient negated if sign(a)^sign(b);
//    remainder takes sign(a). Result is truncated toward zero.
//    0x80000000 / -1 -> LO=0x80000000, HI=0.
//  - Divide by zero: skip iterations; IDLE->DONE. Next cycle hilo_we_o=1, HI=src_a_i,
//    LO={DATA_W{1'b1}}. No exception raised.
//  - flush_i in MUL/DIV/DONE: next state IDLE, hilo_we_o forced 0 that cycle, no HI/LO write.
//    flush_i in IDLE blocks acceptance.
//  - hi_o/lo_o hold their last values when hilo_we_o=0. hilo_we_o is never high two
//    consecutive cycles.
//  - Reset mid-operation: abort immediately; no write after reset release.
// CONFIGURATION
//  FAST_MUL_EN defined: MULT/MULTU use a one-cycle combinational multiply. The MUL state
//    is unused; IDLE->DONE with latency 1 cycle (busy_o high 1 cycle). Divide is unchanged.
//  FAST_MUL_EN undefined: iterative multiply, DATA_W+1 cycle latency as above.
// TESTING
//  1 MULT a=-3 b=7 -> after 33 cycles hilo_we_o=1 for 1 cycle, HI=FFFFFFFF, LO=FFFFFFEB
//    (FAST_MUL_EN: after 1 cycle).
//  2 DIVU a=100 b=7 -> at cycle 33, LO=0000000E, HI=00000002. busy_o high cycles 1..33.
//  3 DIV a=-7 b=2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIV a=80000000 b=FFFFFFFF -> LO=80000000, HI=0.
//  4 DIV a=0x55 b=0 -> next cycle we=1, HI=00000055, LO=FFFFFFFF. busy_o high 1 cycle.
//  5 MTHI a=12345678 with lo_cur=0000AAAA -> next cycle we=1, HI=12345678, LO=0000AAAA.
//    A MTLO presented during busy_o is not accepted until IDLE.
//  6 DIVU started, flush_i at iteration 10 -> no hilo_we_o, busy_o=0 next cycle.
//    Separately: rst_n low mid-MULT -> all outputs 0 immediately, no write afterwards.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// HI/LO sequencer bus: EX-stage op request toward the controller, HI/LO write port back.
interface hilo_muldiv_if #(
  parameter int unsigned DATA_W = 32
);
  logic              op_valid_i;
  logic [2:0]        op_i;
  logic [DATA_W-1:0] src_a_i;
  logic [DATA_W-1:0] src_b_i;
  logic              flush_i;
  logic [DATA_W-1:0] hi_cur_i;
  logic [DATA_W-1:0] lo_cur_i;
  logic              busy_o;
  logic              hilo_we_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output op_valid_i, op_i, src_a_i, src_b_i, flush_i, hi_cur_i, lo_cur_i,
    input  busy_o, hilo_we_o, hi_o, lo_o
  );

  modport slave (
    input  op_valid_i, op_i, src_a_i, src_b_i, flush_i, hi_cur_i, lo_cur_i,
    output busy_o, hilo_we_o, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO write sequencer: MULT/MULTU/DIV/DIVU via iterative shift-add / restoring divide, MTHI/MTLO.
// Optional macro FAST_MUL_EN: single-cycle combinational multiply (divide stays iterative).
module hilo_muldiv_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  hilo_muldiv_if.slave    bus
);

  localparam int unsigned CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [DATA_W-1:0] sh_q, sh_d;     // multiplier / dividend shifting into quotient
  logic [DATA_W-1:0] opb_q, opb_d;   // multiplicand / divisor magnitude
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  // Operand magnitudes and result signs for the op being offered
  logic              is_signed, a_neg, b_neg;
  logic [DATA_W-1:0] abs_a, abs_b;

  always_comb begin
    is_signed = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
    a_neg     = is_signed & bus.src_a_i[DATA_W-1];
    b_neg     = is_signed & bus.src_b_i[DATA_W-1];
    abs_a     = a_neg ? -bus.src_a_i : bus.src_a_i;
    abs_b     = b_neg ? -bus.src_b_i : bus.src_b_i;
  end

  // One shift-add multiply step and one restoring divide step
  logic [DATA_W:0]   mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [DATA_W-1:0] mul_hi, mul_lo, div_rem, div_quo;
  logic [PROD_W-1:0] prod, prod_fix;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
    mul_hi   = mul_sum[DATA_W:1];
    mul_lo   = {mul_sum[0], sh_q[DATA_W-1:1]};
    div_sh   = {acc_q, sh_q[DATA_W-1]};
    div_diff = div_sh - {1'b0, opb_q};
    div_ge   = (div_sh >= {1'b0, opb_q});
    div_rem  = div_ge ? div_diff[DATA_W-1:0] : div_sh[DATA_W-1:0];
    div_quo  = {sh_q[DATA_W-2:0], div_ge};
    prod     = {mul_hi, mul_lo};
    prod_fix = quo_neg_q ? -prod : prod;
  end

`ifdef FAST_MUL_EN
  logic [PROD_W-1:0] fast_prod, fast_fix;

  always_comb begin
    fast_prod = PROD_W'(abs_a) * PROD_W'(abs_b);
    fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    opb_d     = opb_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    we_d      = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.op_valid_i && !bus.flush_i) begin
          case (bus.op_i)
            OP_MTHI: begin
              state_d = S_DONE;
              we_d    = 1'b1;
              hi_d    = bus.src_a_i;
              lo_d    = bus.lo_cur_i;
            end
            OP_MTLO: begin
              state_d = S_DONE;
              we_d    = 1'b1;
              hi_d    = bus.hi_cur_i;
              lo_d    = bus.src_a_i;
            end
            OP_MULT, OP_MULTU: begin
`ifdef FAST_MUL_EN
              state_d = S_DONE;
              we_d    = 1'b1;
              hi_d    = fast_fix[PROD_W-1:DATA_W];
              lo_d    = fast_fix[DATA_W-1:0];
`else
              state_d   = S_MUL;
              cnt_d     = CNT_W'(DATA_W - 1);
              acc_d     = '0;
              sh_d      = abs_b;
              opb_d     = abs_a;
              quo_neg_d = a_neg ^ b_neg;
              rem_neg_d = 1'b0;
`endif
            end
            OP_DIV, OP_DIVU: begin
              if (bus.src_b_i == '0) begin
                // Divide by zero completes at once with a fixed result pattern
                state_d = S_DONE;
                we_d    = 1'b1;
                hi_d    = bus.src_a_i;
                lo_d    = '1;
              end else begin
                state_d   = S_DIV;
                cnt_d     = CNT_W'(DATA_W - 1);
                acc_d     = '0;
                sh_d      = abs_a;
                opb_d     = abs_b;
                quo_neg_d = a_neg ^ b_neg;
                rem_neg_d = a_neg;
              end
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_hi;
        sh_d  = mul_lo;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          we_d    = 1'b1;
          hi_d    = prod_fix[PROD_W-1:DATA_W];
          lo_d    = prod_fix[DATA_W-1:0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        acc_d = div_rem;
        sh_d  = div_quo;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          we_d    = 1'b1;
          hi_d    = rem_neg_q ? -div_rem : div_rem;
          lo_d    = quo_neg_q ? -div_quo : div_quo;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
    endcase

    // Flush aborts any in-flight op and suppresses its write
    if (bus.flush_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      we_d    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      opb_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      opb_q     <= opb_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
      busy_q    <= busy_d;
      we_q      <= we_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.hilo_we_o = we_q;
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: vector table plus busy-hold, flush and reset sequences.
module tb_hilo_muldiv_ctrl;

  localparam int unsigned DATA_W = 32;
`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = DATA_W + 1;
`endif
  localparam int DIV_LAT = DATA_W + 1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi_cur;
    logic [31:0] lo_cur;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_if #(.DATA_W(DATA_W)) bus ();

  hilo_muldiv_ctrl #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hc, input logic [31:0] lc);
    bus.op_valid_i = v;
    bus.op_i       = op;
    bus.src_a_i    = a;
    bus.src_b_i    = b;
    bus.hi_cur_i   = hc;
    bus.lo_cur_i   = lc;
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] hc, input logic [31:0] lc, input int lat,
                              input logic [31:0] hi, input logic [31:0] lo);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi_cur = hc; v.lo_cur = lc;
    v.lat = lat; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  // Issue one op, then sample every cycle after the accept edge
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(1'b1, v.op, v.a, v.b, v.hi_cur, v.lo_cur);
    for (int i = 1; i <= v.lat + 2; i++) begin
      @(negedge clk);
      if (i == 1) bus.op_valid_i = 1'b0;
      chk($sformatf("v%0d we c%0d", idx, i), 32'(bus.hilo_we_o), 32'(i == v.lat));
      chk($sformatf("v%0d busy c%0d", idx, i), 32'(bus.busy_o), 32'(i <= v.lat));
      if (i >= v.lat) begin
        chk($sformatf("v%0d hi c%0d", idx, i), bus.hi_o, v.hi);
        chk($sformatf("v%0d lo c%0d", idx, i), bus.lo_o, v.lo);
      end
    end
  endtask

  vec_t vecs[16];
  int   pulses;
  int   busy_cnt;

  initial begin
    vecs[0]  = mk(3'd1, 32'hFFFFFFFD, 32'd7,        32'h0, 32'h0, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFEB);
    vecs[1]  = mk(3'd2, 32'hFFFFFFFF, 32'd2,        32'h0, 32'h0, MUL_LAT, 32'h00000001, 32'hFFFFFFFE);
    vecs[2]  = mk(3'd1, 32'h80000000, 32'h80000000, 32'h0, 32'h0, MUL_LAT, 32'h40000000, 32'h00000000);
    vecs[3]  = mk(3'd1, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h0, 32'h0, MUL_LAT, 32'hFFFFFFFF, 32'h00000002);
    vecs[4]  = mk(3'd2, 32'h00010000, 32'h00010000, 32'h0, 32'h0, MUL_LAT, 32'h00000001, 32'h00000000);
    vecs[5]  = mk(3'd4, 32'd100,      32'd7,        32'h0, 32'h0, DIV_LAT, 32'h00000002, 32'h0000000E);
    vecs[6]  = mk(3'd3, 32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
    vecs[7]  = mk(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, DIV_LAT, 32'h00000000, 32'h80000000);
    vecs[8]  = mk(3'd3, 32'd7,        32'hFFFFFFFE, 32'h0, 32'h0, DIV_LAT, 32'h00000001, 32'hFFFFFFFD);
    vecs[9]  = mk(3'd4, 32'hFFFFFFFF, 32'd1,        32'h0, 32'h0, DIV_LAT, 32'h00000000, 32'hFFFFFFFF);
    vecs[10] = mk(3'd4, 32'd5,        32'd9,        32'h0, 32'h0, DIV_LAT, 32'h00000005, 32'h00000000);
    vecs[11] = mk(3'd3, 32'h00000055, 32'h0,        32'h0, 32'h0, 1,       32'h00000055, 32'hFFFFFFFF);
    vecs[12] = mk(3'd4, 32'hDEADBEEF, 32'h0,        32'h0, 32'h0, 1,       32'hDEADBEEF, 32'hFFFFFFFF);
    vecs[13] = mk(3'd5, 32'h12345678, 32'h0, 32'h11111111, 32'h0000AAAA, 1, 32'h12345678, 32'h0000AAAA);
    vecs[14] = mk(3'd6, 32'hCAFEF00D, 32'h0, 32'h0BADBEEF, 32'h22222222, 1, 32'h0BADBEEF, 32'hCAFEF00D);
    vecs[15] = mk(3'd7, 32'hFFFFFFFF, 32'd3, 32'h33333333, 32'h44444444, 0, 32'h0BADBEEF, 32'hCAFEF00D);

    rst_n = 1'b0;
    bus.flush_i = 1'b0;
    drive(1'b0, 3'd0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(bus.busy_o), 32'd0);
    chk("rst we",   32'(bus.hilo_we_o), 32'd0);
    chk("rst hi",   bus.hi_o, 32'h0);
    chk("rst lo",   bus.lo_o, 32'h0);
    rst_n = 1'b1;

    run_vec(mk(3'd0, 32'h1, 32'h1, 32'h0, 32'h0, 0, 32'h0, 32'h0), 99);
    for (int k = 0; k < 16; k++) run_vec(vecs[k], k);

    // MTLO held while a DIVU is busy is only taken once the controller is idle
    @(negedge clk);
    drive(1'b1, 3'd4, 32'd100, 32'd7, '0, '0);
    @(negedge clk);
    drive(1'b1, 3'd6, 32'h77, 32'h0, 32'h99, 32'h0);
    pulses = 0;
    for (int i = 1; i <= 36; i++) begin
      if (i > 1) @(negedge clk);
      if (i <= 32) begin
        if (bus.hilo_we_o) pulses++;
        if (!bus.busy_o) pulses++;
      end
      if (i == 33) begin
        chk("hold we c33", 32'(bus.hilo_we_o), 32'd1);
        chk("hold busy c33", 32'(bus.busy_o), 32'd1);
        chk("hold hi c33", bus.hi_o, 32'h2);
        chk("hold lo c33", bus.lo_o, 32'hE);
      end
      if (i == 34) begin
        chk("hold we c34", 32'(bus.hilo_we_o), 32'd0);
        chk("hold busy c34", 32'(bus.busy_o), 32'd0);
      end
      if (i == 35) begin
        chk("hold we c35", 32'(bus.hilo_we_o), 32'd1);
        chk("hold busy c35", 32'(bus.busy_o), 32'd1);
        chk("hold hi c35", bus.hi_o, 32'h99);
        chk("hold lo c35", bus.lo_o, 32'h77);
        bus.op_valid_i = 1'b0;
      end
      if (i == 36) chk("hold busy c36", 32'(bus.busy_o), 32'd0);
    end
    chk("hold early events", 32'(pulses), 32'd0);

    // Flush at DIVU iteration 10 drops the op with no write
    @(negedge clk);
    drive(1'b1, 3'd4, 32'd100, 32'd7, '0, '0);
    @(negedge clk);
    bus.op_valid_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush busy c10", 32'(bus.busy_o), 32'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush busy c11", 32'(bus.busy_o), 32'd0);
    chk("flush we c11", 32'(bus.hilo_we_o), 32'd0);
    pulses = 0;
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.hilo_we_o) pulses++;
      if (bus.busy_o) busy_cnt++;
    end
    chk("flush no write", 32'(pulses), 32'd0);
    chk("flush no busy", 32'(busy_cnt), 32'd0);
    chk("flush hi hold", bus.hi_o, 32'h99);
    chk("flush lo hold", bus.lo_o, 32'h77);

    // Flush while idle blocks acceptance
    @(negedge clk);
    drive(1'b1, 3'd5, 32'h1, 32'h0, '0, '0);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.op_valid_i = 1'b0;
    bus.flush_i = 1'b0;
    chk("idle flush busy", 32'(bus.busy_o), 32'd0);
    chk("idle flush we", 32'(bus.hilo_we_o), 32'd0);
    @(negedge clk);
    chk("idle flush hi", bus.hi_o, 32'h99);

    // Asynchronous reset in the middle of a MULT
    @(negedge clk);
    drive(1'b1, 3'd1, 32'd5, 32'd6, '0, '0);
    @(negedge clk);
    bus.op_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(bus.busy_o), 32'd0);
    chk("arst we",   32'(bus.hilo_we_o), 32'd0);
    chk("arst hi",   bus.hi_o, 32'h0);
    chk("arst lo",   bus.lo_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    busy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.hilo_we_o) pulses++;
      if (bus.busy_o) busy_cnt++;
    end
    chk("arst no write", 32'(pulses), 32'd0);
    chk("arst no busy", 32'(busy_cnt), 32'd0);
    chk("arst hi after", bus.hi_o, 32'h0);
    chk("arst lo after", bus.lo_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
